counter_run_controller: RTL

//  Run/pause/clear sequencer for the board's 16-bit hex-display counter.
//  - Turns two raw pushbuttons and a rate select into paced increments.
//  - Owns the count register and adds a stop-at-limit or wrap-at-limit mode.
//  - count drives four hex_display instances (HEX3..HEX0) at the top level.
//  - Replaces hand-clocking the counter from KEY[0]; everything runs on CLOCK_50.

---
 rtl/counter_run_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/counter_run_controller.sv
// Run/pause/clear sequencer and count register for the hex display.
// Buttons are synchronised, edge-detected and turned into paced increments.
//
// Ports:
//   CLOCK_50    sole clock, rising edge
//   reset       asynchronous, active-high
//   key_run_n   raw run/pause button, active-low
//   key_clear_n raw clear button, active-low
//   rate_sel    increment rate select (11 = every clock)
//   wrap_mode   1 = wrap to 0 at limit, 0 = stop in DONE
//   limit       terminal count value
//   count       current count
//   tick        1-cycle pulse per applied increment
//   running     state is RUN
//   done        state is DONE
module counter_run_controller #(
  parameter int WIDTH = 16,
  parameter int DIV0  = 50_000_000,
  parameter int DIV1  = 25_000_000,
  parameter int DIV2  = 5_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_run_n,
  input  logic             key_clear_n,
  input  logic [1:0]       rate_sel,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done
);

  localparam int DM01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int DMAX = (DM01 > DIV2) ? DM01 : DIV2;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t state_q, state_d;

  // [0],[1] synchroniser, [2] previous synced level
  logic [2:0] run_sh, clr_sh;
  logic       run_p, clr_p;

  logic [1:0]       rate_q;
  logic             rate_chg;
  logic [DW-1:0]    div_q, div_d, div_term;
  logic [WIDTH-1:0] count_d, count_nxt;
  logic             tick_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      run_sh <= 3'b111;
      clr_sh <= 3'b111;
      run_p  <= 1'b0;
      clr_p  <= 1'b0;
    end else begin
      run_sh <= {run_sh[1:0], key_run_n};
      clr_sh <= {clr_sh[1:0], key_clear_n};
      run_p  <= run_sh[2] & ~run_sh[1];
      clr_p  <= clr_sh[2] & ~clr_sh[1];
    end
  end

  always_comb begin
    case (rate_sel)
      2'b00:   div_term = DW'(DIV0 - 1);
      2'b01:   div_term = DW'(DIV1 - 1);
      2'b10:   div_term = DW'(DIV2 - 1);
      default: div_term = '0;
    endcase
  end

  assign rate_chg = (rate_q != rate_sel);

  assign count_nxt = (wrap_mode && count == limit)
                   ? '0 : count + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count;
    div_d   = div_q;
    tick_d  = 1'b0;
    if (clr_p) begin
      state_d = IDLE;
      count_d = '0;
      div_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          div_d = '0;
          if (run_p) state_d = RUN;
        end
        RUN: begin
          if (rate_chg) begin
            div_d = '0;
          end else if (div_q == div_term) begin
            div_d   = '0;
            tick_d  = 1'b1;
            count_d = count_nxt;
            if (!wrap_mode && count_nxt == limit)
              state_d = DONE;
          end else begin
            div_d = div_q + 1'b1;
          end
          // a press in the same cycle still pauses
          if (run_p) state_d = PAUSE;
        end
        PAUSE: begin
          if (rate_chg) div_d = '0;
          if (run_p) state_d = RUN;
        end
        DONE: begin
          div_d = '0;
          if (run_p) begin
            state_d = IDLE;
            count_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      div_q   <= '0;
      rate_q  <= 2'b00;
      tick    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      div_q   <= div_d;
      rate_q  <= rate_sel;
      tick    <= tick_d;
      running <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

endmodule
